// File: rtl/fifo_status_pkg.sv
// Shared types and sizing helpers for the status FIFO.
package fifo_status_pkg;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return unsigned'($clog2(depth) + 1);
    endfunction

    // Sticky error flags, cleared only by flush or reset.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

endpackage

// File: rtl/fifo_status_if.sv
// Producer/consumer side of the status FIFO, grouped as one bus.
interface fifo_status_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 4
);
    logic                  cs;
    logic                  clr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output cs, clr, wr_en, rd_en, data_in,
        input  data_out, data_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  cs, clr, wr_en, rd_en, data_in,
        output data_out, data_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_status_mem.sv
// Storage array: synchronous write, asynchronous read, no reset.
module fifo_status_mem #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata_c
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];
endmodule

// File: rtl/fifo_status.sv
// Synchronous FIFO with occupancy, thresholds, sticky errors, flush and read mode.
module fifo_status
    import fifo_status_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned AFULL_LEVEL  = 6,
    parameter int unsigned AEMPTY_LEVEL = 2,
    parameter int unsigned FWFT         = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    fifo_status_if.slave  bus
);
    localparam int unsigned PTR_W  = ptr_w(FIFO_DEPTH);
    localparam int unsigned ADDR_W = PTR_W - 1;
    localparam int unsigned CNT_W  = PTR_W;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_status: FIFO_DEPTH must be a power of two >= 2");
    end
    if ((AFULL_LEVEL < 1) || (AFULL_LEVEL > FIFO_DEPTH)) begin : g_bad_afull
        $error("fifo_status: AFULL_LEVEL out of range");
    end
    if (AEMPTY_LEVEL > FIFO_DEPTH - 1) begin : g_bad_aempty
        $error("fifo_status: AEMPTY_LEVEL out of range");
    end

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_nxt_c;
    err_flags_t            err_q;
    err_flags_t            err_nxt_c;
    logic                  empty_q;
    logic                  full_q;
    logic                  aempty_q;
    logic                  afull_q;
    logic                  clr_c;
    logic                  rd_acc_c;
    logic                  wr_acc_c;
    logic                  rd_go_c;
    logic                  wr_go_c;
    logic [DATA_WIDTH-1:0] rdata_c;

    // Accept/reject decisions; flush overrides any transfer in the same cycle.
    always_comb begin
        clr_c    = bus.cs & bus.clr;
        rd_acc_c = bus.cs & bus.rd_en & ~empty_q;
        wr_acc_c = bus.cs & bus.wr_en & (~full_q | rd_acc_c);
        rd_go_c  = rd_acc_c & ~clr_c;
        wr_go_c  = wr_acc_c & ~clr_c;
    end

    // Next occupancy and sticky error flags.
    always_comb begin
        count_nxt_c = count_q;
        err_nxt_c   = err_q;
        if (clr_c) begin
            count_nxt_c = '0;
            err_nxt_c   = '0;
        end else begin
            case ({wr_go_c, rd_go_c})
                2'b10:   count_nxt_c = count_q + CNT_W'(1);
                2'b01:   count_nxt_c = count_q - CNT_W'(1);
                default: count_nxt_c = count_q;
            endcase
            if (bus.cs & bus.wr_en & ~wr_acc_c) begin
                err_nxt_c.overflow = 1'b1;
            end
            if (bus.cs & bus.rd_en & empty_q) begin
                err_nxt_c.underflow = 1'b1;
            end
        end
    end

    // Pointers, count, errors and status flags, all registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            err_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr   <= clr_c ? '0 : wr_ptr + PTR_W'(wr_go_c);
            rd_ptr   <= clr_c ? '0 : rd_ptr + PTR_W'(rd_go_c);
            count_q  <= count_nxt_c;
            err_q    <= err_nxt_c;
            empty_q  <= (count_nxt_c == '0);
            full_q   <= (count_nxt_c == CNT_W'(FIFO_DEPTH));
            aempty_q <= (count_nxt_c <= CNT_W'(AEMPTY_LEVEL));
            afull_q  <= (count_nxt_c >= CNT_W'(AFULL_LEVEL));
        end
    end

    fifo_status_mem #(
        .DEPTH  (FIFO_DEPTH),
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we      (wr_go_c),
        .waddr   (wr_ptr[ADDR_W-1:0]),
        .wdata   (bus.data_in),
        .raddr   (rd_ptr[ADDR_W-1:0]),
        .rdata_c (rdata_c)
    );

    if (FWFT != 0) begin : g_fwft
        assign bus.data_out   = rdata_c;
        assign bus.data_valid = ~empty_q;
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  dvalid_q;

        // Registered read: capture head on accept, one-cycle valid strobe.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dout_q   <= '0;
                dvalid_q <= 1'b0;
            end else begin
                dvalid_q <= rd_go_c;
                if (rd_go_c) begin
                    dout_q <= rdata_c;
                end
            end
        end

        assign bus.data_out   = dout_q;
        assign bus.data_valid = dvalid_q;
    end

    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = aempty_q;
    assign bus.almost_full  = afull_q;
    assign bus.overflow     = err_q.overflow;
    assign bus.underflow    = err_q.underflow;
endmodule

// File: tb/tb_fifo_status.sv
// Directed bench: FWFT build (u_a) and registered-read build (u_b) share stimulus.
module tb_fifo_status;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fifo_status_if #(.DATA_WIDTH(32), .CNT_W(4)) if_a ();
    fifo_status_if #(.DATA_WIDTH(32), .CNT_W(4)) if_b ();

    fifo_status #(.FIFO_DEPTH(8), .DATA_WIDTH(32), .AFULL_LEVEL(6), .AEMPTY_LEVEL(2), .FWFT(1))
        u_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
    fifo_status #(.FIFO_DEPTH(8), .DATA_WIDTH(32), .AFULL_LEVEL(6), .AEMPTY_LEVEL(2), .FWFT(0))
        u_b (.clk(clk), .reset_n(reset_n), .bus(if_b));

    always #5 clk = ~clk;

    task automatic drive(input logic cs, input logic clr, input logic wr, input logic rd,
                         input logic [31:0] d);
        if_a.cs = cs; if_a.clr = clr; if_a.wr_en = wr; if_a.rd_en = rd; if_a.data_in = d;
        if_b.cs = cs; if_b.clr = clr; if_b.wr_en = wr; if_b.rd_en = rd; if_b.data_in = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic push(input logic [31:0] d);
        drive(1'b1, 1'b0, 1'b1, 1'b0, d);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pop();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        reset_n = 1'b1;
        push(32'h1);
        push(32'h2);
        push(32'h3);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h4);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (if_a.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", if_a.count); end
        checks++; if (if_a.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", if_a.empty); end
        checks++; if (if_a.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", if_a.full); end
        checks++; if (if_a.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", if_a.almost_empty); end
        checks++; if (if_a.almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", if_a.almost_full); end
        checks++; if ({if_a.overflow, if_a.underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {if_a.overflow, if_a.underflow}); end
        checks++; if (if_b.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dvalid_b got %b exp 0", if_b.data_valid); end
        checks++; if (if_b.data_out !== 32'h0) begin errors++; $display("FAIL reset_dout_b got %0h exp 0", if_b.data_out); end
        step();
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(32'hA0 + 32'(i));
            checks++; if (if_a.count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, if_a.count, i + 1); end
            checks++; if (if_a.almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, if_a.almost_full, (i + 1 >= 6)); end
            checks++; if (if_a.almost_empty !== (i + 1 <= 2)) begin errors++; $display("FAIL fill_aempty[%0d] got %b exp %b", i, if_a.almost_empty, (i + 1 <= 2)); end
            checks++; if (if_a.full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, if_a.full, (i == 7)); end
        end
        checks++; if (if_a.overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %b exp 0", if_a.overflow); end
        push(32'hEE);
        checks++; if (if_a.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", if_a.overflow); end
        checks++; if (if_a.count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", if_a.count); end
        checks++; if (if_a.data_out !== 32'hA0) begin errors++; $display("FAIL ovf_head got %0h exp a0", if_a.data_out); end
        step();
        checks++; if (if_a.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", if_a.overflow); end
    endtask

    task automatic test_full_rdwr();
        logic [31:0] exp_q [8];
        do_reset();
        for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
        checks++; if (if_a.data_out !== 32'hA0) begin errors++; $display("FAIL full_head got %0h exp a0", if_a.data_out); end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hB0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (if_a.count !== 4'd8) begin errors++; $display("FAIL full_rw_count got %0d exp 8", if_a.count); end
        checks++; if (if_a.overflow !== 1'b0) begin errors++; $display("FAIL full_rw_ovf got %b exp 0", if_a.overflow); end
        checks++; if (if_a.full !== 1'b1) begin errors++; $display("FAIL full_rw_full got %b exp 1", if_a.full); end
        for (int i = 0; i < 7; i++) exp_q[i] = 32'hA1 + 32'(i);
        exp_q[7] = 32'hB0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (if_a.data_out !== exp_q[i]) begin errors++; $display("FAIL drain[%0d] got %0h exp %0h", i, if_a.data_out, exp_q[i]); end
            pop();
        end
        checks++; if (if_a.empty !== 1'b1 || if_a.count !== 4'd0) begin errors++; $display("FAIL drain_empty got e=%b c=%0d exp e=1 c=0", if_a.empty, if_a.count); end
        push(32'h5A);
        checks++; if (if_a.data_out !== 32'h5A) begin errors++; $display("FAIL wrap_head got %0h exp 5a", if_a.data_out); end
    endtask

    task automatic test_empty_rdwr();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h77);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (if_a.underflow !== 1'b1) begin errors++; $display("FAIL empty_rw_udf got %b exp 1", if_a.underflow); end
        checks++; if (if_a.count !== 4'd1) begin errors++; $display("FAIL empty_rw_count got %0d exp 1", if_a.count); end
        checks++; if (if_a.data_out !== 32'h77) begin errors++; $display("FAIL empty_rw_head got %0h exp 77", if_a.data_out); end
        pop();
        checks++; if (if_a.empty !== 1'b1) begin errors++; $display("FAIL empty_rw_drain got %b exp 1", if_a.empty); end
    endtask

    task automatic test_clr();
        do_reset();
        pop();
        for (int i = 0; i < 9; i++) push(32'hC0 + 32'(i));
        for (int i = 0; i < 3; i++) pop();
        checks++; if ({if_a.count, if_a.overflow, if_a.underflow} !== {4'd5, 2'b11}) begin errors++; $display("FAIL pre_clr got c=%0d o=%b u=%b exp c=5 o=1 u=1", if_a.count, if_a.overflow, if_a.underflow); end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hDD);
        step();
        checks++; if (if_a.count !== 4'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", if_a.count); end
        checks++; if (if_a.empty !== 1'b1 || if_a.almost_empty !== 1'b1) begin errors++; $display("FAIL clr_empty got e=%b ae=%b exp 1 1", if_a.empty, if_a.almost_empty); end
        checks++; if ({if_a.overflow, if_a.underflow} !== 2'b00) begin errors++; $display("FAIL clr_err got %b exp 00", {if_a.overflow, if_a.underflow}); end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h44);
        step();
        checks++; if (if_a.count !== 4'd0 || if_a.underflow !== 1'b0) begin errors++; $display("FAIL cs_low got c=%0d u=%b exp c=0 u=0", if_a.count, if_a.underflow); end
        push(32'h99);
        checks++; if (if_a.count !== 4'd1 || if_a.data_out !== 32'h99) begin errors++; $display("FAIL post_clr got c=%0d d=%0h exp c=1 d=99", if_a.count, if_a.data_out); end
    endtask

    task automatic test_registered_read();
        do_reset();
        push(32'h11);
        push(32'h22);
        checks++; if (if_b.count !== 4'd2 || if_b.data_valid !== 1'b0) begin errors++; $display("FAIL rr_pre got c=%0d v=%b exp c=2 v=0", if_b.count, if_b.data_valid); end
        pop();
        checks++; if (if_b.data_valid !== 1'b1 || if_b.data_out !== 32'h11) begin errors++; $display("FAIL rr_first got v=%b d=%0h exp v=1 d=11", if_b.data_valid, if_b.data_out); end
        step();
        checks++; if (if_b.data_valid !== 1'b0 || if_b.data_out !== 32'h11) begin errors++; $display("FAIL rr_hold1 got v=%b d=%0h exp v=0 d=11", if_b.data_valid, if_b.data_out); end
        step();
        checks++; if (if_b.data_out !== 32'h11) begin errors++; $display("FAIL rr_hold2 got %0h exp 11", if_b.data_out); end
        pop();
        checks++; if (if_b.data_valid !== 1'b1 || if_b.data_out !== 32'h22) begin errors++; $display("FAIL rr_second got v=%b d=%0h exp v=1 d=22", if_b.data_valid, if_b.data_out); end
        step();
        checks++; if (if_b.data_valid !== 1'b0 || if_b.empty !== 1'b1) begin errors++; $display("FAIL rr_done got v=%b e=%b exp v=0 e=1", if_b.data_valid, if_b.empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_rdwr();
        test_empty_rdwr();
        test_clr();
        test_registered_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
